// File: rtl/ldst_control_sequencer.sv
// ldst_control_sequencer
// Control sequencer for the memory-class instructions ld, ldi and st.
// Fetch occupies T0-T2 and execute occupies T3-T7. The datapath strobes are
// decoded from the registered state. In T3 the decode also uses the live
// opcode. After T3 it uses the opcode captured in T3.
// Memory steps (T1, T6 for ld, T7 for st) last MEM_LAT cycles each. A wait
// counter tracks them.
// Optional feature: define SEQ_SINGLE_STEP_EN to add a Step input. Non-idle
// states then advance only on cycles where Step=1. Strobes that load a
// register are gated by Step.
module ldst_control_sequencer #(
    parameter int               OPC_W   = 5,
    parameter logic [OPC_W-1:0] OP_LD   = 5'b00000,
    parameter logic [OPC_W-1:0] OP_LDI  = 5'b00001,
    parameter logic [OPC_W-1:0] OP_ST   = 5'b00010,
    parameter int               MEM_LAT = 1,
    parameter int               CNT_W   = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             Step,
`endif
    input  logic [OPC_W-1:0] opcode,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             ZLOout,
    output logic             Cout,
    output logic             BAout,
    output logic             Gra,
    output logic             Grb,
    output logic             Rin,
    output logic             Rout,
    output logic             Read,
    output logic             Write,
    output logic             Busy,
    output logic             Done,
    output logic             Illegal,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_ILLEGAL
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [OPC_W-1:0]   opc_q, opc_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic adv;
    logic wait_last;
    logic is_ld, is_ldi, is_st;
    logic legal_now;
    logic final_step;
    logic complete;

    // raw decodes before Step gating
    logic pcin_r, incpc_r, marin_r, mdrin_r, irin_r, zin_r, rin_r, write_r;

`ifdef SEQ_SINGLE_STEP_EN
    assign adv = Step;
`else
    assign adv = 1'b1;
`endif

    assign wait_last = (wait_q == WAIT_W'(MEM_LAT - 1));
    assign is_ld     = (opc_q == OP_LD);
    assign is_ldi    = (opc_q == OP_LDI);
    assign is_st     = (opc_q == OP_ST);
    assign legal_now = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);

    // final step of each instruction; Done only on the advancing cycle
    assign final_step = ((state_q == S_T5) && is_ldi) ||
                        ((state_q == S_T7) && is_ld)  ||
                        ((state_q == S_T7) && is_st && wait_last);
    assign complete   = final_step && adv;

    // next-state, wait counter, captured opcode and retired counter
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        opc_d     = opc_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                wait_d = '0;
                if (Run) state_d = S_T0;
            end
            S_T0: if (adv) state_d = S_T1;
            S_T1: if (adv) begin
                if (wait_last) begin
                    wait_d  = '0;
                    state_d = S_T2;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_T2: if (adv) state_d = S_T3;
            S_T3: if (adv) begin
                opc_d   = opcode;
                state_d = legal_now ? S_T4 : S_ILLEGAL;
            end
            S_T4: if (adv) state_d = S_T5;
            S_T5: if (adv && !is_ldi) state_d = S_T6;
            S_T6: if (adv) begin
                if (is_ld && !wait_last) begin
                    wait_d = wait_q + 1'b1;
                end else begin
                    wait_d  = '0;
                    state_d = S_T7;
                end
            end
            S_T7: if (adv && is_st && !wait_last) wait_d = wait_q + 1'b1;
            S_ILLEGAL: state_d = S_ILLEGAL;
            default: state_d = S_IDLE;
        endcase
        if (complete) begin
            wait_d    = '0;
            retired_d = retired_q + 1'b1;
            state_d   = Run ? S_T0 : S_IDLE;
        end
    end

    // state register with synchronous reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            opc_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            opc_q     <= opc_d;
            retired_q <= retired_d;
        end
    end

    // strobe decode from registered state (live opcode used in T3 only)
    always_comb begin
        PCout   = 1'b0;
        MDRout  = 1'b0;
        Yin     = 1'b0;
        ZLOout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Rout    = 1'b0;
        Read    = 1'b0;
        pcin_r  = 1'b0;
        incpc_r = 1'b0;
        marin_r = 1'b0;
        mdrin_r = 1'b0;
        irin_r  = 1'b0;
        zin_r   = 1'b0;
        rin_r   = 1'b0;
        write_r = 1'b0;
        case (state_q)
            S_T0: begin
                PCout   = 1'b1;
                marin_r = 1'b1;
                incpc_r = 1'b1;
                zin_r   = 1'b1;
            end
            S_T1: begin
                Read    = 1'b1;
                ZLOout  = 1'b1;
                pcin_r  = wait_last;
                mdrin_r = wait_last;
            end
            S_T2: begin
                MDRout = 1'b1;
                irin_r = 1'b1;
            end
            S_T3: if (legal_now) begin
                Grb   = 1'b1;
                BAout = 1'b1;
                Yin   = 1'b1;
            end
            S_T4: begin
                Cout  = 1'b1;
                zin_r = 1'b1;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_ldi) begin
                    Gra   = 1'b1;
                    rin_r = 1'b1;
                end else begin
                    marin_r = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read    = 1'b1;
                    mdrin_r = wait_last;
                end else begin
                    Gra     = 1'b1;
                    Rout    = 1'b1;
                    mdrin_r = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1;
                    Gra    = 1'b1;
                    rin_r  = 1'b1;
                end else begin
                    write_r = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign PCin      = pcin_r  & adv;
    assign IncPC     = incpc_r & adv;
    assign MARin     = marin_r & adv;
    assign MDRin     = mdrin_r & adv;
    assign IRin      = irin_r  & adv;
    assign Zin       = zin_r   & adv;
    assign Rin       = rin_r   & adv;
    assign Write     = write_r & adv;
    assign Done      = complete;
    assign Busy      = (state_q != S_IDLE) && (state_q != S_ILLEGAL);
    assign Illegal   = (state_q == S_ILLEGAL);
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ldst_control_sequencer.sv
// Testbench for ldst_control_sequencer.
// A driver issues instructions with random Run and opcode noise. For each
// cycle it pushes the expected strobe/status/retired vector, built from the
// instruction step tables. A negedge monitor pops each vector and compares.
module tb_ldst_control_sequencer;

  localparam int OPC_W   = 5;
  localparam int MEM_LAT = 3;
  localparam int CNT_W   = 3;
  localparam int W       = 21 + CNT_W;
  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [20:0] M_PCOUT  = 21'h1 << 0;
  localparam logic [20:0] M_PCIN   = 21'h1 << 1;
  localparam logic [20:0] M_INCPC  = 21'h1 << 2;
  localparam logic [20:0] M_MARIN  = 21'h1 << 3;
  localparam logic [20:0] M_MDRIN  = 21'h1 << 4;
  localparam logic [20:0] M_MDROUT = 21'h1 << 5;
  localparam logic [20:0] M_IRIN   = 21'h1 << 6;
  localparam logic [20:0] M_YIN    = 21'h1 << 7;
  localparam logic [20:0] M_ZIN    = 21'h1 << 8;
  localparam logic [20:0] M_ZLO    = 21'h1 << 9;
  localparam logic [20:0] M_COUT   = 21'h1 << 10;
  localparam logic [20:0] M_BAOUT  = 21'h1 << 11;
  localparam logic [20:0] M_GRA    = 21'h1 << 12;
  localparam logic [20:0] M_GRB    = 21'h1 << 13;
  localparam logic [20:0] M_RIN    = 21'h1 << 14;
  localparam logic [20:0] M_ROUT   = 21'h1 << 15;
  localparam logic [20:0] M_READ   = 21'h1 << 16;
  localparam logic [20:0] M_WRITE  = 21'h1 << 17;
  localparam logic [20:0] M_BUSY   = 21'h1 << 18;
  localparam logic [20:0] M_DONE   = 21'h1 << 19;
  localparam logic [20:0] M_ILL    = 21'h1 << 20;

  // clock / reset block
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Run = 1'b0;
  logic [OPC_W-1:0] opcode = '0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, ZLOout;
  logic Cout, BAout, Gra, Grb, Rin, Rout, Read, Write, Busy, Done, Illegal;
  logic [CNT_W-1:0] retired;
  logic [3:0] state_dbg;
`ifdef SEQ_SINGLE_STEP_EN
  logic step_in = 1'b1;
`endif

  always #5 Clock = ~Clock;

  ldst_control_sequencer #(
    .OPC_W(OPC_W), .OP_LD(OP_LD), .OP_LDI(OP_LDI), .OP_ST(OP_ST),
    .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run),
`ifdef SEQ_SINGLE_STEP_EN
    .Step(step_in),
`endif
    .opcode(opcode),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout),
    .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Rin(Rin), .Rout(Rout),
    .Read(Read), .Write(Write), .Busy(Busy), .Done(Done), .Illegal(Illegal),
    .retired(retired), .state_dbg(state_dbg)
  );

  logic [W-1:0] act;
  assign act = {retired, Illegal, Done, Busy, Write, Read, Rout, Rin, Grb, Gra,
                BAout, Cout, ZLOout, Zin, Yin, IRin, MDRout, MDRin, MARin,
                IncPC, PCin, PCout};

  // scoreboard state
  logic [W-1:0]  exp_q[$];
  logic [20:0]   seq_q[$];
  int            model_ret = 0;
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  // monitor: one expected vector per cycle, sampled mid-cycle
  always @(negedge Clock) begin
    if (mon_en) begin
      cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL exp_empty cycle=%0d act=%h required=<queued vector>", cyc, act);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL cycle_vec cycle=%0d act=%h required=%h", cyc, act, e);
        end
      end
    end
  end

  // instruction step table: one entry per cycle of the instruction
  task automatic build_seq(input logic [4:0] op);
    bit legal;
    legal = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    seq_q.delete();
    seq_q.push_back(M_BUSY | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    for (int i = 0; i < MEM_LAT; i++)
      seq_q.push_back(M_BUSY | M_READ | M_ZLO | ((i == MEM_LAT-1) ? (M_MDRIN | M_PCIN) : 21'h0));
    seq_q.push_back(M_BUSY | M_MDROUT | M_IRIN);
    if (!legal) begin
      seq_q.push_back(M_BUSY);
      return;
    end
    seq_q.push_back(M_BUSY | M_GRB | M_BAOUT | M_YIN);
    seq_q.push_back(M_BUSY | M_COUT | M_ZIN);
    if (op == OP_LDI) begin
      seq_q.push_back(M_BUSY | M_ZLO | M_GRA | M_RIN | M_DONE);
    end else begin
      seq_q.push_back(M_BUSY | M_ZLO | M_MARIN);
      if (op == OP_LD) begin
        for (int i = 0; i < MEM_LAT; i++)
          seq_q.push_back(M_BUSY | M_READ | ((i == MEM_LAT-1) ? M_MDRIN : 21'h0));
        seq_q.push_back(M_BUSY | M_MDROUT | M_GRA | M_RIN | M_DONE);
      end else begin
        seq_q.push_back(M_BUSY | M_GRA | M_ROUT | M_MDRIN);
        for (int i = 0; i < MEM_LAT; i++)
          seq_q.push_back(M_BUSY | M_WRITE | ((i == MEM_LAT-1) ? M_DONE : 21'h0));
      end
    end
  endtask

  // advance one clock and queue the expectation for the cycle now starting
  task automatic push_cycle(input logic [20:0] m);
    @(posedge Clock);
    #1;
    exp_q.push_back({CNT_W'(model_ret), m});
  endtask

  // drive an instruction; caller has Run=1 so the next edge enters T0.
  // n_elems < 0 runs the whole instruction, otherwise only its first n cycles.
  task automatic run_instr(input logic [4:0] op, input int n_elems);
    int n;
    build_seq(op);
    n = (n_elems < 0) ? seq_q.size() : n_elems;
    for (int i = 0; i < n; i++) begin
      if (i > 0) Run = 1'($urandom_range(0, 1));
      opcode = (i < MEM_LAT + 2) ? 5'($urandom_range(0, 31)) : op;
      push_cycle(seq_q[i]);
      if ((seq_q[i] & M_DONE) != 21'h0) model_ret++;
    end
  endtask

  function automatic logic [4:0] rand_legal();
    int r;
    r = $urandom_range(0, 2);
    return (r == 0) ? OP_LD : (r == 1) ? OP_LDI : OP_ST;
  endfunction

  // stimulus
  initial begin
    Reset = 1'b1;
    Run = 1'b0;
    push_cycle(21'h0);
    mon_en = 1'b1;
    Reset = 1'b0;
    push_cycle(21'h0);
    push_cycle(21'h0);

    // single ldi, then back to idle
    Run = 1'b1; run_instr(OP_LDI, -1);
    Run = 1'b0; push_cycle(21'h0); push_cycle(21'h0);
    // single ld and st with multi-cycle memory steps
    Run = 1'b1; run_instr(OP_LD, -1);
    Run = 1'b0; push_cycle(21'h0);
    Run = 1'b1; run_instr(OP_ST, -1);
    Run = 1'b0; push_cycle(21'h0);
    // three back-to-back ldi
    Run = 1'b1;
    repeat (3) begin
      run_instr(OP_LDI, -1);
      Run = 1'b1;
    end
    Run = 1'b0; push_cycle(21'h0);

    // random instruction mix with random idle gaps (counter wraps repeatedly)
    repeat (40) begin
      Run = 1'b1;
      run_instr(rand_legal(), -1);
      if ($urandom_range(0, 1) == 1) begin
        Run = 1'b0;
        repeat ($urandom_range(1, 3)) push_cycle(21'h0);
      end
    end
    Run = 1'b0; push_cycle(21'h0);

    // reset during T4 of ld aborts it
    Run = 1'b1;
    run_instr(OP_LD, MEM_LAT + 4);
    Reset = 1'b1;
    model_ret = 0;
    push_cycle(21'h0);
    Reset = 1'b0; Run = 1'b0;
    push_cycle(21'h0);

    // two instructions, then an illegal opcode traps until reset
    Run = 1'b1; run_instr(OP_ST, -1);
    Run = 1'b1; run_instr(OP_LDI, -1);
    Run = 1'b1; run_instr(5'($urandom_range(3, 31)), -1);
    repeat (6) begin
      Run = 1'($urandom_range(0, 1));
      push_cycle(M_ILL);
    end
    Reset = 1'b1;
    model_ret = 0;
    push_cycle(21'h0);
    Reset = 1'b0; Run = 1'b0;
    push_cycle(21'h0);

    // recovery after the trap
    Run = 1'b1; run_instr(OP_LDI, -1);
    Run = 1'b0; push_cycle(21'h0); push_cycle(21'h0);

    @(negedge Clock);
    #1;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL exp_drain left=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog time_limit act=expired required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
